pattern_mem_sweeper: RTL

- Parametrised single-clock memory with its own built-in sweep engine.
- The engine fills the array with an address-derived pattern, or checks the array against that pattern in place, counting mismatches and recording the first failing index.
- The array is declared public read/write so external VPI/DPI code can inspect and corrupt it between sweeps.
- Sits in the regression harness as a generalised, self-checking successor to the fixed 16x32 public memory tests.

---
 rtl/pattern_mem_sweeper_pkg.sv | 52 +++++
 rtl/pattern_mem_sweeper_if.sv | 38 +++
 rtl/pattern_mem_sweeper_array.sv | 55 +++++
 rtl/pattern_mem_sweeper.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_mem_sweeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_mem_pkg
//  Purpose  : Shared types and the address-derived pattern function used by
//             the pattern memory sweeper and its storage array.
//  Contents : mode_e  - sweep kind (fill / check)
//             pat_e   - pattern selector
//             state_e - sweep engine states
//             pattern_f() - expected value for a given index
//  Revision : 1.0 - initial release
// ============================================================================
package pattern_mem_pkg;

  typedef enum logic [1:0] {
    MODE_FILL  = 2'd0,
    MODE_CHECK = 2'd1
  } mode_e;

  typedef enum logic [1:0] {
    PAT_IDX = 2'd0,
    PAT_INV = 2'd1,
    PAT_XOR = 2'd2
  } pat_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_CHECK = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Computed at 64 bits and masked to the requested width; callers narrow the
  // result with a size cast. The index is zero-extended before inversion, so
  // ~index sets every bit above the index width up to the data width.
  function automatic logic [63:0] pattern_f(input logic [63:0] idx,
                                            input pat_e        pat,
                                            input logic [63:0] seed,
                                            input int unsigned width);
    logic [63:0] r;
    logic [63:0] mask;
    case (pat)
      PAT_INV: r = ~idx;
      PAT_XOR: r = idx ^ seed;
      default: r = idx;
    endcase
    mask = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return r & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_mem_sweeper_if.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_mem_sweeper_if
//  Purpose  : Host access bus of the pattern memory sweeper.
//  Signals  : host_we/host_re   - write / read strobes (host -> memory)
//             host_addr         - array index
//             host_wdata        - write data
//             host_rdata        - read data, one cycle after host_re
//             host_rvalid       - read-data valid pulse
//             host_err          - out-of-range access pulse
//  Modports : master (host side), slave (memory side)
//  Revision : 1.0 - initial release
// ============================================================================
interface pattern_mem_sweeper_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) ();

  logic             host_we;
  logic             host_re;
  logic [AW-1:0]    host_addr;
  logic [WIDTH-1:0] host_wdata;
  logic [WIDTH-1:0] host_rdata;
  logic             host_rvalid;
  logic             host_err;

  modport master (
    output host_we, host_re, host_addr, host_wdata,
    input  host_rdata, host_rvalid, host_err
  );

  modport slave (
    input  host_we, host_re, host_addr, host_wdata,
    output host_rdata, host_rvalid, host_err
  );

endinterface
`default_nettype wire

// File: rtl/pattern_mem_sweeper_array.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_mem_array
//  Purpose  : Storage for the pattern memory sweeper. One write port and one
//             registered read port; the top level arbitrates between host and
//             sweep engine and guarantees indices are in range.
//  Ports    : clk, reset_l        - clock, async active-low reset (read reg)
//             we, waddr, wdata    - write port, takes effect at posedge
//             re, raddr           - read strobe and index
//             rdata               - registered read data (old data on a
//                                   same-cycle write to the same index)
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int BASE  = 1,
  parameter int AW    = $clog2(BASE + DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             reset_l,
  input  wire logic             we,
  input  wire logic [AW-1:0]    waddr,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             re,
  input  wire logic [AW-1:0]    raddr,
  output logic      [WIDTH-1:0] rdata
);

  // Kept as a plain, directly indexed array named mem with the natural index
  // range so external inspection code can find and modify entries by index.
  // Contents are deliberately not reset.
  logic [WIDTH-1:0] mem [BASE:BASE+DEPTH-1];

  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register samples pre-write contents, giving read-old-data behaviour.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pattern_mem_sweeper.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_mem_sweeper
//  Purpose  : Memory with a built-in sweep engine that fills the array with an
//             address-derived pattern or checks it in place, counting
//             mismatches and capturing the first failing index.
//  Ports    : clk, reset_l        - clock, async active-low reset
//             host (slave)        - host read/write bus, served only in IDLE
//             start               - one-cycle sweep launch pulse
//             mode, pat, seed,
//             descend             - sweep settings, sampled with start
//             busy, done          - sweep in progress / completion pulse
//             err_cnt, first_bad  - result of the last CHECK sweep
//  Revision : 1.0 - initial release
// ============================================================================
module pattern_mem_sweeper
  import pattern_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int BASE  = 1,
  parameter int AW    = $clog2(BASE + DEPTH),
  parameter int CW    = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_l,
  pattern_mem_sweeper_if.slave  host,
  input  wire logic             start,
  input  wire logic [1:0]       mode,
  input  wire logic [1:0]       pat,
  input  wire logic [WIDTH-1:0] seed,
  input  wire logic             descend,
  output logic                  busy,
  output logic                  done,
  output logic      [CW-1:0]    err_cnt,
  output logic      [AW-1:0]    first_bad
);

  localparam logic [AW-1:0] IDX_LO = AW'(BASE);
  localparam logic [AW-1:0] IDX_HI = AW'(BASE + DEPTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic [AW-1:0]    ptr_q,         ptr_d;
  pat_e             pat_q,         pat_d;
  logic [WIDTH-1:0] seed_q,        seed_d;
  logic             desc_q,        desc_d;
  logic             busy_q,        busy_d;
  logic             done_q,        done_d;
  logic [CW-1:0]    err_cnt_q,     err_cnt_d;
  logic [AW-1:0]    first_bad_q,   first_bad_d;
  logic             cmp_vld_q,     cmp_vld_d;
  logic [AW-1:0]    cmp_ptr_q,     cmp_ptr_d;
  logic             host_rvalid_q, host_rvalid_d;
  logic             host_err_q,    host_err_d;
  logic             host_oor_q,    host_oor_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             host_ok;
  logic             host_in_range;
  logic             ptr_last;
  logic [AW-1:0]    ptr_next;
  logic [WIDTH-1:0] exp_ptr;
  logic [WIDTH-1:0] exp_cmp;

  logic             arr_we;
  logic [AW-1:0]    arr_waddr;
  logic [WIDTH-1:0] arr_wdata;
  logic             arr_re;
  logic [AW-1:0]    arr_raddr;
  logic [WIDTH-1:0] arr_rdata;

  assign host_ok       = (state_q == S_IDLE);
  assign host_in_range = (host.host_addr >= IDX_LO) && (host.host_addr <= IDX_HI);

  // Termination is on reaching the end index, so the pointer never wraps.
  assign ptr_last = (ptr_q == (desc_q ? IDX_LO : IDX_HI));
  assign ptr_next = desc_q ? (ptr_q - 1'b1) : (ptr_q + 1'b1);

  assign exp_ptr = WIDTH'(pattern_f(64'(ptr_q), pat_q, 64'(seed_q), WIDTH));
  assign exp_cmp = WIDTH'(pattern_f(64'(cmp_ptr_q), pat_q, 64'(seed_q), WIDTH));

  // Array port arbitration: the engine owns the array outside IDLE and the
  // host is only served in IDLE, so the two never collide.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = host.host_addr;
    arr_wdata = host.host_wdata;
    arr_re    = 1'b0;
    arr_raddr = host.host_addr;
    if (state_q == S_FILL) begin
      arr_we    = 1'b1;
      arr_waddr = ptr_q;
      arr_wdata = exp_ptr;
    end else if (host_ok && host.host_we && host_in_range) begin
      arr_we    = 1'b1;
    end
    if (state_q == S_CHECK) begin
      arr_re    = 1'b1;
      arr_raddr = ptr_q;
    end else if (host_ok && host.host_re && host_in_range) begin
      arr_re    = 1'b1;
    end
  end

  pattern_mem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .BASE  (BASE),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .reset_l (reset_l),
    .we      (arr_we),
    .waddr   (arr_waddr),
    .wdata   (arr_wdata),
    .re      (arr_re),
    .raddr   (arr_raddr),
    .rdata   (arr_rdata)
  );

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    pat_d         = pat_q;
    seed_d        = seed_q;
    desc_d        = desc_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_cnt_d     = err_cnt_q;
    first_bad_d   = first_bad_q;
    cmp_vld_d     = 1'b0;
    cmp_ptr_d     = cmp_ptr_q;
    host_rvalid_d = host_ok && host.host_re;
    host_err_d    = host_ok && (host.host_re || host.host_we) && !host_in_range;
    host_oor_d    = host_oor_q;

    // Out-of-range reads must return zero; remember it until the next
    // accepted host read instead of touching the array.
    if (host_ok && host.host_re) begin
      host_oor_d = !host_in_range;
    end

    // Compare stage: data read last cycle against the pattern of its index.
    // err_cnt never returns to zero once bumped, so zero marks "no miss yet".
    if (cmp_vld_q && (arr_rdata != exp_cmp)) begin
      if (err_cnt_q == '0) begin
        first_bad_d = cmp_ptr_q;
      end
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (pat)
            2'd1:    pat_d = PAT_INV;
            2'd2:    pat_d = PAT_XOR;
            default: pat_d = PAT_IDX;
          endcase
          seed_d      = seed;
          desc_d      = descend;
          ptr_d       = descend ? IDX_HI : IDX_LO;
          err_cnt_d   = '0;
          first_bad_d = '0;
          busy_d      = 1'b1;
          state_d     = (mode == 2'(MODE_CHECK)) ? S_CHECK : S_FILL;
        end
      end
      S_FILL: begin
        if (ptr_last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_next;
        end
      end
      S_CHECK: begin
        cmp_vld_d = 1'b1;
        cmp_ptr_d = ptr_q;
        if (ptr_last) begin
          state_d = S_DRAIN;
        end else begin
          ptr_d = ptr_next;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      pat_q         <= PAT_IDX;
      seed_q        <= '0;
      desc_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_cnt_q     <= '0;
      first_bad_q   <= '0;
      cmp_vld_q     <= 1'b0;
      cmp_ptr_q     <= '0;
      host_rvalid_q <= 1'b0;
      host_err_q    <= 1'b0;
      host_oor_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      pat_q         <= pat_d;
      seed_q        <= seed_d;
      desc_q        <= desc_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_cnt_q     <= err_cnt_d;
      first_bad_q   <= first_bad_d;
      cmp_vld_q     <= cmp_vld_d;
      cmp_ptr_q     <= cmp_ptr_d;
      host_rvalid_q <= host_rvalid_d;
      host_err_q    <= host_err_d;
      host_oor_q    <= host_oor_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err_cnt          = err_cnt_q;
  assign first_bad        = first_bad_q;
  assign host.host_rdata  = host_oor_q ? '0 : arr_rdata;
  assign host.host_rvalid = host_rvalid_q;
  assign host.host_err    = host_err_q;

endmodule
`default_nettype wire
